// File: rtl/mpc_muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mpc_muldiv_ctrl_if
//  Purpose  : EX-stage op bus and multiplier handshake for mpc_muldiv_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface mpc_muldiv_ctrl_if #(
    parameter int DW = 32
);
    // EX-stage side
    logic              iOpValid;
    logic [2:0]        iOp;
    logic [DW-1:0]     iRs;
    logic [DW-1:0]     iRt;
    logic              iFlush;
    logic              oStall;
    logic              oRdValid;
    logic [DW-1:0]     oRdData;
    logic [DW-1:0]     oHi;
    logic [DW-1:0]     oLo;
    logic              oBusy;
    // Multiplier side
    logic              oMulValid;
    logic [DW-1:0]     oMulA;
    logic [DW-1:0]     oMulB;
    logic [2*DW-1:0]   iMul;
    logic              iMulOverflow;
    logic              iMulReady;

    modport master (
        output iOpValid, iOp, iRs, iRt, iFlush, iMul, iMulOverflow, iMulReady,
        input  oStall, oRdValid, oRdData, oHi, oLo, oBusy, oMulValid, oMulA, oMulB
    );

    modport slave (
        input  iOpValid, iOp, iRs, iRt, iFlush, iMul, iMulOverflow, iMulReady,
        output oStall, oRdValid, oRdData, oHi, oLo, oBusy, oMulValid, oMulA, oMulB
    );
endinterface
`default_nettype wire

// File: rtl/mpc_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mpc_muldiv_ctrl
//  Purpose  : HI/LO owner and sequencer for the iterative unsigned multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module mpc_muldiv_ctrl #(
    parameter int DW = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mpc_muldiv_ctrl_if.slave  bus
);
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_FIXUP = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_MFHI  = 3'd2;
    localparam logic [2:0] c_OP_MFLO  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    logic [2:0]        r_state;
    logic              r_neg;
    logic [DW-1:0]     r_mulA;
    logic [DW-1:0]     r_mulB;
    logic [2*DW-1:0]   r_prod;
    logic [DW-1:0]     r_hi;
    logic [DW-1:0]     r_lo;
    logic              r_rdValid;
    logic [DW-1:0]     r_rdData;

    logic              w_isOp;
    logic              w_stall;
    logic              w_accept;
    logic              w_signed;
    logic [DW-1:0]     w_magRs;
    logic [DW-1:0]     w_magRt;
    logic [2*DW-1:0]   w_fixed;
    logic              w_unusedOverflow;

    // The multiplier cannot overflow a double-width product
    assign w_unusedOverflow = bus.iMulOverflow;

    // Ops 6/7 are pipeline no-ops and must never hold up the EX stage
    assign w_isOp   = (bus.iOp <= c_OP_MTLO);
    assign w_stall  = bus.iOpValid & w_isOp & (r_state != c_IDLE);
    assign w_accept = bus.iOpValid & w_isOp & ~w_stall & ~bus.iFlush;

    assign w_signed = (bus.iOp == c_OP_MULT);
    // Two's-complement negate of 0x80..0 wraps to itself, which is the correct magnitude
    assign w_magRs  = (w_signed & bus.iRs[DW-1]) ? (~bus.iRs + DW'(1)) : bus.iRs;
    assign w_magRt  = (w_signed & bus.iRt[DW-1]) ? (~bus.iRt + DW'(1)) : bus.iRt;
    assign w_fixed  = r_neg ? (~r_prod + {{(2*DW-1){1'b0}}, 1'b1}) : r_prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_neg     <= 1'b0;
            r_mulA    <= '0;
            r_mulB    <= '0;
            r_prod    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
        end else begin
            r_rdValid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        case (bus.iOp)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_neg   <= w_signed & (bus.iRs[DW-1] ^ bus.iRt[DW-1]);
                                r_mulA  <= w_magRs;
                                r_mulB  <= w_magRt;
                                r_state <= c_ISSUE;
                            end
                            c_OP_MFHI: begin
                                r_rdValid <= 1'b1;
                                r_rdData  <= r_hi;
                            end
                            c_OP_MFLO: begin
                                r_rdValid <= 1'b1;
                                r_rdData  <= r_lo;
                            end
                            c_OP_MTHI: r_hi <= bus.iRs;
                            c_OP_MTLO: r_lo <= bus.iRs;
                            default: ;
                        endcase
                    end
                end
                c_ISSUE: begin
                    // The start pulse is already on the wire this cycle, so a flush must drain it
                    r_state <= bus.iFlush ? c_DRAIN : c_WAIT;
                end
                c_WAIT: begin
                    if (bus.iMulReady) begin
                        if (bus.iFlush) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_prod  <= bus.iMul;
                            r_state <= c_FIXUP;
                        end
                    end else if (bus.iFlush) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_FIXUP: begin
                    if (!bus.iFlush) begin
                        r_hi <= w_fixed[2*DW-1:DW];
                        r_lo <= w_fixed[DW-1:0];
                    end
                    r_state <= c_IDLE;
                end
                c_DRAIN: begin
                    if (bus.iMulReady) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.oStall    = w_stall;
    assign bus.oRdValid  = r_rdValid;
    assign bus.oRdData   = r_rdData;
    assign bus.oHi       = r_hi;
    assign bus.oLo       = r_lo;
    assign bus.oBusy     = (r_state != c_IDLE);
    assign bus.oMulValid = (r_state == c_ISSUE);
    assign bus.oMulA     = r_mulA;
    assign bus.oMulB     = r_mulB;
endmodule
`default_nettype wire

// File: tb/tb_mpc_muldiv_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mpc_muldiv_ctrl
//  Purpose  : Self-checking bench for mpc_muldiv_ctrl with a latency-programmable multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mpc_muldiv_ctrl;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mpc_muldiv_ctrl_if #(.DW(DW)) bus();
    mpc_muldiv_ctrl #(.DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;
    int mulLat = 4;
    int pending = 0;
    logic [2*DW-1:0] mulProd = '0;
    logic [DW-1:0] mHi = '0;
    logic [DW-1:0] mLo = '0;

    // Multiplier model: ready pulses mulLat cycles after the start pulse
    initial begin
        bus.iMulReady = 1'b0;
        bus.iMul = '0;
        bus.iMulOverflow = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending = 0;
                bus.iMulReady = 1'b0;
            end else begin
                if (pending > 0) begin
                    pending--;
                    bus.iMulReady = (pending == 0);
                end else begin
                    bus.iMulReady = 1'b0;
                end
                if (bus.oMulValid) begin
                    pending = mulLat;
                    mulProd = {32'(bus.oMulA)} * 64'(bus.oMulB);
                    mulProd = 64'(bus.oMulA) * 64'(bus.oMulB);
                end
            end
            bus.iMul = bus.iMulReady ? mulProd : {$urandom, $urandom};
            bus.iMulOverflow = 1'($urandom);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    function automatic logic [2*DW-1:0] refProd(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] xa, xb;
        if (op == 3'd0) begin
            xa = {{DW{a[DW-1]}}, a};
            xb = {{DW{b[DW-1]}}, b};
        end else begin
            xa = {{DW{1'b0}}, a};
            xb = {{DW{1'b0}}, b};
        end
        return xa * xb;
    endfunction

    function automatic logic [DW-1:0] refMag(input logic [2:0] op, input logic [DW-1:0] a);
        logic [DW-1:0] z;
        z = '0;
        return (op == 3'd0 && a[DW-1]) ? (z - a) : a;
    endfunction

    function automatic logic [DW-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Present one op (at #1 after a posedge), wait out any stall, check its effect
    task automatic do_op(input logic [2:0] op, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
        int guard;
        logic [DW-1:0] expRd;
        bus.iOp = op; bus.iRs = rs; bus.iRt = rt; bus.iOpValid = 1'b1;
        #1;
        guard = 0;
        while (bus.oStall && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 200) begin
            total++; bad++;
            $display("FAIL do_op_accept stall=%b required=0", bus.oStall);
        end
        expRd = (op == 3'd2) ? mHi : mLo;
        @(posedge clk); #1;
        bus.iOpValid = 1'b0;
        case (op)
            3'd0, 3'd1: {mHi, mLo} = refProd(op, rs, rt);
            3'd4: mHi = rs;
            3'd5: mLo = rs;
            default: ;
        endcase
        if (op == 3'd2 || op == 3'd3) begin
            total++;
            if (bus.oRdValid !== 1'b1 || bus.oRdData !== expRd) begin
                bad++;
                $display("FAIL do_op_read op=%0d valid=%b data=%h required valid=1 data=%h", op, bus.oRdValid, bus.oRdData, expRd);
            end
        end else begin
            guard = 0;
            while (bus.oBusy && guard < 100) begin
                @(posedge clk); #1; guard++;
            end
            total++;
            if (bus.oBusy !== 1'b0 || bus.oHi !== mHi || bus.oLo !== mLo || bus.oRdValid !== 1'b0) begin
                bad++;
                $display("FAIL do_op_hilo op=%0d busy=%b hi=%h lo=%h rdv=%b required busy=0 hi=%h lo=%h rdv=0",
                         op, bus.oBusy, bus.oHi, bus.oLo, bus.oRdValid, mHi, mLo);
            end
        end
    endtask

    // Cycle-exact multiply: HI/LO must change exactly n+2 edges after acceptance
    task automatic mul_timed(input logic [2:0] op, input logic [DW-1:0] rs, input logic [DW-1:0] rt, input int n);
        int pulses;
        logic [2*DW-1:0] p;
        mulLat = n;
        p = refProd(op, rs, rt);
        bus.iOp = op; bus.iRs = rs; bus.iRt = rt; bus.iOpValid = 1'b1;
        #1;
        total++;
        if (bus.oStall !== 1'b0) begin
            bad++; $display("FAIL mul_idle_stall stall=%b required=0", bus.oStall);
        end
        @(posedge clk); #1;
        bus.iOpValid = 1'b0;
        pulses = 0;
        total++;
        if (bus.oMulA !== refMag(op, rs) || bus.oMulB !== refMag(op, rt)) begin
            bad++;
            $display("FAIL mul_operands a=%h b=%h required a=%h b=%h", bus.oMulA, bus.oMulB, refMag(op, rs), refMag(op, rt));
        end
        for (int k = 0; k <= n + 3; k++) begin
            if (bus.oMulValid === 1'b1) pulses++;
            if (k == n + 1) begin
                total++;
                if (bus.oBusy !== 1'b1 || bus.oHi !== mHi || bus.oLo !== mLo) begin
                    bad++;
                    $display("FAIL mul_early busy=%b hi=%h lo=%h required busy=1 hi=%h lo=%h", bus.oBusy, bus.oHi, bus.oLo, mHi, mLo);
                end
            end
            if (k == n + 2) begin
                {mHi, mLo} = p;
                total++;
                if (bus.oBusy !== 1'b0 || bus.oHi !== mHi || bus.oLo !== mLo) begin
                    bad++;
                    $display("FAIL mul_result busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h", bus.oBusy, bus.oHi, bus.oLo, mHi, mLo);
                end
            end
            if (k < n + 3) begin
                @(posedge clk); #1;
            end
        end
        total++;
        if (pulses != 1) begin
            bad++; $display("FAIL mul_pulse_count got=%0d required=1", pulses);
        end
    endtask

    // Multiply with a flush raised kf cycles after acceptance for dur cycles
    task automatic flush_at(input logic [DW-1:0] rs, input logic [DW-1:0] rt, input int n, input int kf, input int dur);
        int pulses;
        int idleAt;
        int expIdle;
        mulLat = n;
        bus.iOp = 3'($urandom_range(0, 1)); bus.iRs = rs; bus.iRt = rt; bus.iOpValid = 1'b1;
        @(posedge clk); #1;
        bus.iOpValid = 1'b0;
        pulses = 0;
        idleAt = -1;
        expIdle = (kf <= n) ? n + 1 : n + 2;
        for (int k = 0; k <= n + 4; k++) begin
            if (bus.oMulValid === 1'b1) pulses++;
            if (idleAt < 0 && bus.oBusy === 1'b0) idleAt = k;
            if (k == kf) bus.iFlush = 1'b1;
            if (k == kf + dur) bus.iFlush = 1'b0;
            @(posedge clk); #1;
        end
        bus.iFlush = 1'b0;
        total++;
        if (idleAt != expIdle || pulses != 1 || bus.oHi !== mHi || bus.oLo !== mLo) begin
            bad++;
            $display("FAIL flush n=%0d kf=%0d idleAt=%0d pulses=%0d hi=%h lo=%h required idleAt=%0d pulses=1 hi=%h lo=%h",
                     n, kf, idleAt, pulses, bus.oHi, bus.oLo, expIdle, mHi, mLo);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        total++;
        if (bus.oHi !== '0 || bus.oLo !== '0 || bus.oBusy !== 1'b0 || bus.oRdValid !== 1'b0 || bus.oMulValid !== 1'b0) begin
            bad++;
            $display("FAIL reset_init hi=%h lo=%h busy=%b rdv=%b mv=%b required all 0", bus.oHi, bus.oLo, bus.oBusy, bus.oRdValid, bus.oMulValid);
        end
        do_op(3'd4, 32'hDEAD_BEEF, '0);
        do_op(3'd5, 32'h0BAD_F00D, '0);
        mulLat = 10;
        bus.iOp = 3'd0; bus.iRs = 32'd9; bus.iRt = 32'd9; bus.iOpValid = 1'b1;
        @(posedge clk); #1 bus.iOpValid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        bus.iOpValid = 1'b1;
        #1;
        mHi = '0; mLo = '0;
        total++;
        if (bus.oBusy !== 1'b0 || bus.oHi !== '0 || bus.oLo !== '0 || bus.oMulValid !== 1'b0 || bus.oStall !== 1'b0) begin
            bad++;
            $display("FAIL reset_midwait busy=%b hi=%h lo=%h mv=%b stall=%b required all 0", bus.oBusy, bus.oHi, bus.oLo, bus.oMulValid, bus.oStall);
        end
        bus.iOpValid = 1'b0;
        reset = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        total++;
        if (bus.oBusy !== 1'b0 || bus.oHi !== '0 || bus.oLo !== '0) begin
            bad++;
            $display("FAIL reset_quiet busy=%b hi=%h lo=%h required 0", bus.oBusy, bus.oHi, bus.oLo);
        end
    endtask

    task automatic test_multu();
        mul_timed(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
        mul_timed(3'd1, 32'h8000_0000, 32'h0000_0003, 1);
    endtask

    task automatic test_signed();
        mul_timed(3'd0, 32'hFFFF_FFFE, 32'd3, 1);
        mul_timed(3'd0, 32'h8000_0000, 32'h8000_0000, 2);
        mul_timed(3'd0, 32'h8000_0000, 32'd1, 3);
        mul_timed(3'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 5);
    endtask

    task automatic test_stall();
        int stalls;
        mulLat = 3;
        bus.iOp = 3'd0; bus.iRs = 32'd7; bus.iRt = 32'd6; bus.iOpValid = 1'b1;
        @(posedge clk); #1;
        {mHi, mLo} = refProd(3'd0, 32'd7, 32'd6);
        bus.iOp = 3'd3;
        #1;
        stalls = 0;
        while (bus.oStall === 1'b1 && stalls < 50) begin
            stalls++;
            @(posedge clk); #2;
        end
        @(posedge clk); #1;
        bus.iOpValid = 1'b0;
        total++;
        if (stalls != 5) begin
            bad++; $display("FAIL stall_cycles got=%0d required=5", stalls);
        end
        total++;
        if (bus.oRdValid !== 1'b1 || bus.oRdData !== mLo) begin
            bad++; $display("FAIL stall_mflo valid=%b data=%h required valid=1 data=%h", bus.oRdValid, bus.oRdData, mLo);
        end
        @(posedge clk); #1;
        total++;
        if (bus.oRdValid !== 1'b0) begin
            bad++; $display("FAIL stall_rdvalid_width valid=%b required=0", bus.oRdValid);
        end
    endtask

    task automatic test_flush();
        do_op(3'd4, 32'h1111_2222, '0);
        do_op(3'd5, 32'h3333_4444, '0);
        mulLat = 5;
        bus.iOp = 3'd1; bus.iRs = 32'hFFFF_0000; bus.iRt = 32'h0001_0000; bus.iOpValid = 1'b1;
        @(posedge clk); #1 bus.iOpValid = 1'b0;
        @(posedge clk); #1 bus.iFlush = 1'b1;
        @(posedge clk); #1 bus.iFlush = 1'b0;
        bus.iOp = 3'd2; bus.iOpValid = 1'b1;
        #1;
        total++;
        if (bus.oBusy !== 1'b1 || bus.oStall !== 1'b1) begin
            bad++; $display("FAIL flush_drain busy=%b stall=%b required 1 1", bus.oBusy, bus.oStall);
        end
        bus.iOpValid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        total++;
        if (bus.oBusy !== 1'b0 || bus.oHi !== mHi || bus.oLo !== mLo) begin
            bad++; $display("FAIL flush_discard busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h", bus.oBusy, bus.oHi, bus.oLo, mHi, mLo);
        end
        do_op(3'd0, 32'd5, 32'd5);
        flush_at(32'h1234_5678, 32'h9ABC_DEF0, 3, 0, 1);
        flush_at(32'h7FFF_FFFF, 32'h8000_0000, 3, 3, 1);
        flush_at(32'hCAFE_BABE, 32'd12345, 2, 3, 1);
        flush_at(32'd100, 32'd200, 4, 1, 3);
    endtask

    task automatic test_mtmf();
        logic [2:0] ops [4];
        logic [DW-1:0] vals [4];
        logic [DW-1:0] expRd;
        ops[0] = 3'd4; vals[0] = 32'h1234_5678;
        ops[1] = 3'd5; vals[1] = 32'h9ABC_DEF0;
        ops[2] = 3'd2; vals[2] = $urandom;
        ops[3] = 3'd3; vals[3] = $urandom;
        for (int i = 0; i < 4; i++) begin
            bus.iOp = ops[i]; bus.iRs = vals[i]; bus.iRt = $urandom; bus.iOpValid = 1'b1;
            #1;
            total++;
            if (bus.oStall !== 1'b0) begin
                bad++; $display("FAIL mtmf_stall i=%0d stall=%b required=0", i, bus.oStall);
            end
            expRd = (ops[i] == 3'd2) ? mHi : mLo;
            if (ops[i] == 3'd4) mHi = vals[i];
            if (ops[i] == 3'd5) mLo = vals[i];
            @(posedge clk); #1;
            total++;
            if (ops[i] >= 3'd4) begin
                if (bus.oRdValid !== 1'b0 || bus.oHi !== mHi || bus.oLo !== mLo) begin
                    bad++; $display("FAIL mtmf_write i=%0d hi=%h lo=%h required hi=%h lo=%h", i, bus.oHi, bus.oLo, mHi, mLo);
                end
            end else if (bus.oRdValid !== 1'b1 || bus.oRdData !== expRd) begin
                bad++; $display("FAIL mtmf_read i=%0d valid=%b data=%h required valid=1 data=%h", i, bus.oRdValid, bus.oRdData, expRd);
            end
        end
        bus.iOpValid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            mulLat = $urandom_range(1, 6);
            if ($urandom_range(0, 7) == 0) begin
                flush_at(pickOperand(), pickOperand(), mulLat, $urandom_range(0, mulLat + 1), $urandom_range(1, 2));
            end else begin
                do_op(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
            end
        end
    endtask

    initial begin
        bus.iOpValid = 1'b0;
        bus.iOp = 3'd7;
        bus.iRs = '0;
        bus.iRt = '0;
        bus.iFlush = 1'b0;
        test_reset();
        test_multu();
        test_signed();
        test_stall();
        test_flush();
        test_mtmf();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
